// File: rtl/stack_ctrl_pkg.sv
// Shared types and encodings for the stack sequencer: FSM states, decoded-field
// encodings and the SP update helper.
package stack_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_TOP,
        ST_RD_NXT,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_t;

    localparam logic [1:0] UPD_SP   = 2'b00;
    localparam logic [1:0] UPD_INC  = 2'b01;
    localparam logic [1:0] UPD_DEC2 = 2'b10;
    localparam logic [1:0] UPD_DEC1 = 2'b11;

    localparam logic [1:0] WSRC_NONE = 2'b00;
    localparam logic [1:0] WSRC_ALU  = 2'b01;
    localparam logic [1:0] WSRC_DMEM = 2'b10;
    localparam logic [1:0] WSRC_PC   = 2'b11;

    localparam logic [1:0] PCSRC_TEMP   = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_POP    = 2'b10;

    // Width-agnostic: callers truncate the result to their SP width, which gives the wrap.
    function automatic logic [31:0] sp_next(input logic [31:0] sp, input logic [1:0] upd);
        case (upd)
            UPD_INC:  return sp + 32'd1;
            UPD_DEC2: return sp - 32'd2;
            UPD_DEC1: return sp - 32'd1;
            default:  return sp;
        endcase
    endfunction

endpackage

// File: rtl/stack_sp_calc.sv
// Combinational SP arithmetic: next SP, required stack depth and the
// overflow/underflow conditions for one decoded instruction.
module stack_sp_calc
    import stack_ctrl_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic [AW:0] i_sp,
    input  logic [1:0]  i_upd_mode,
    input  logic [1:0]  i_wr_src,
    input  logic        i_alu_src,
    output logic [AW:0] o_new_sp,
    output logic [1:0]  o_need,
    output logic        o_overflow,
    output logic        o_underflow
);
    localparam int SPW = AW + 1;

    assign o_new_sp = SPW'(sp_next(32'(i_sp), i_upd_mode));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        o_need = 2'd0;
        if (i_upd_mode == UPD_DEC2 ||
            (i_upd_mode == UPD_DEC1 && i_wr_src == WSRC_ALU && !i_alu_src)) begin
            o_need = 2'd2;
        end else if (i_upd_mode == UPD_DEC1 ||
                     (i_upd_mode == UPD_SP && i_wr_src != WSRC_NONE)) begin
            o_need = 2'd1;
        end
    end

    assign o_overflow  = (i_upd_mode == UPD_INC) && (i_sp == SPW'(DEPTH));
    assign o_underflow = i_sp < SPW'(o_need);

endmodule

// File: rtl/stack_seq_ctrl.sv
// Multi-cycle stack sequencer: operand fetch, ALU strobe, dmem access, writeback, SP/PC update.
// Optional `STACK_BOUNDS_CHECK_EN rejects under/overflowing instructions at accept and sets err.
module stack_seq_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          alu_op,
    input  logic [1:0]    pc_src,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [1:0]    wr_src,
    input  logic          alu_src,
    input  logic [1:0]    upd_mode,
    output logic          alu_op_q,
    output logic [AW-1:0] stk_addr,
    output logic          stk_re,
    output logic          stk_we,
    output logic [DW-1:0] stk_wdata,
    input  logic [DW-1:0] stk_rdata,
    output logic [DW-1:0] op_top,
    output logic [DW-1:0] op_nxt,
    output logic          alu_go,
    input  logic [DW-1:0] alu_result,
    output logic          dmem_req,
    output logic          dmem_we,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    input  logic [DW-1:0] pc_plus1,
    output logic          pc_we,
    output logic [1:0]    pc_sel,
    output logic [AW:0]   sp,
    output logic          done,
    output logic          err
);
    localparam int SPW = AW + 1;

    state_t         r_state, w_state_nxt;
    logic [SPW-1:0] r_sp;
    logic [DW-1:0]  r_op_top, r_op_nxt, r_alu_q, r_dmem_q;
    logic           r_alu_op, r_mem_read, r_mem_write, r_alu_src, r_abort, r_exec_d;
    logic [1:0]     r_pc_src, r_wr_src, r_upd_mode;

    logic           w_accept, w_bounds_fail, w_overflow, w_underflow;
    logic [SPW-1:0] w_new_sp;
    logic [1:0]     w_need, w_calc_upd, w_calc_wr;
    logic           w_calc_src;

    assign w_accept = instr_valid && (r_state == ST_IDLE);

    // In IDLE the bounds check looks at the incoming fields; afterwards at the latched ones.
    assign w_calc_upd = (r_state == ST_IDLE) ? upd_mode : r_upd_mode;
    assign w_calc_wr  = (r_state == ST_IDLE) ? wr_src   : r_wr_src;
    assign w_calc_src = (r_state == ST_IDLE) ? alu_src  : r_alu_src;

    stack_sp_calc #(.AW(AW), .DEPTH(DEPTH)) u_sp_calc (
        .i_sp        (r_sp),
        .i_upd_mode  (w_calc_upd),
        .i_wr_src    (w_calc_wr),
        .i_alu_src   (w_calc_src),
        .o_new_sp    (w_new_sp),
        .o_need      (w_need),
        .o_overflow  (w_overflow),
        .o_underflow (w_underflow)
    );

`ifdef STACK_BOUNDS_CHECK_EN
    logic r_err;
    assign w_bounds_fail = w_overflow | w_underflow;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_err <= 1'b0;
        else if (w_accept && w_bounds_fail) r_err <= 1'b1;
    end
    assign err = r_err;
`else
    logic w_unused_bounds;
    assign w_unused_bounds = w_overflow | w_underflow | (|w_need);
    assign w_bounds_fail   = 1'b0;
    assign err             = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        instr_ready = 1'b0;
        stk_re      = 1'b0;
        stk_we      = 1'b0;
        stk_addr    = '0;
        stk_wdata   = '0;
        alu_go      = 1'b0;
        dmem_req    = 1'b0;
        pc_we       = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) w_state_nxt = w_bounds_fail ? ST_WB : ST_RD_TOP;
            end
            ST_RD_TOP: begin
                stk_re      = (r_sp >= SPW'(1));
                stk_addr    = AW'(r_sp - SPW'(1));
                w_state_nxt = ST_RD_NXT;
            end
            ST_RD_NXT: begin
                stk_re      = (r_sp >= SPW'(2));
                stk_addr    = AW'(r_sp - SPW'(2));
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                alu_go      = 1'b1;
                w_state_nxt = (r_mem_read || r_mem_write) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) w_state_nxt = ST_WB;
            end
            ST_WB: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
                if (!r_abort) begin
                    pc_we = 1'b1;
                    if (r_wr_src != WSRC_NONE) begin
                        stk_we   = 1'b1;
                        stk_addr = AW'(w_new_sp - SPW'(1));
                        unique case (r_wr_src)
                            WSRC_ALU:  stk_wdata = r_exec_d ? alu_result : r_alu_q;
                            WSRC_DMEM: stk_wdata = r_dmem_q;
                            WSRC_PC:   stk_wdata = pc_plus1;
                            default:   stk_wdata = '0;
                        endcase
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp        <= '0;
            r_op_top    <= '0;
            r_op_nxt    <= '0;
            r_alu_q     <= '0;
            r_dmem_q    <= '0;
            r_alu_op    <= 1'b0;
            r_pc_src    <= 2'b00;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wr_src    <= 2'b00;
            r_alu_src   <= 1'b0;
            r_upd_mode  <= 2'b00;
            r_abort     <= 1'b0;
            r_exec_d    <= 1'b0;
        end else begin
            r_exec_d <= (r_state == ST_EXEC);
            if (w_accept) begin
                r_alu_op    <= alu_op;
                r_pc_src    <= pc_src;
                r_mem_read  <= mem_read;
                r_mem_write <= mem_write;
                r_wr_src    <= wr_src;
                r_alu_src   <= alu_src;
                r_upd_mode  <= upd_mode;
                r_abort     <= w_bounds_fail;
            end
            if (r_state == ST_RD_NXT) r_op_top <= (r_sp >= SPW'(1)) ? stk_rdata : '0;
            if (r_state == ST_EXEC)   r_op_nxt <= (r_sp >= SPW'(2)) ? stk_rdata : '0;
            // The ALU result is held so a dmem wait cannot lose it.
            if (r_exec_d)                      r_alu_q  <= alu_result;
            if (r_state == ST_MEM && dmem_ack) r_dmem_q <= dmem_rdata;
            if (r_state == ST_WB && !r_abort)  r_sp     <= w_new_sp;
        end
    end

    assign alu_op_q = r_alu_op;
    assign pc_sel   = r_pc_src;
    assign dmem_we  = dmem_req & r_mem_write;
    assign op_top   = r_op_top;
    assign op_nxt   = r_op_nxt;
    assign sp       = r_sp;

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Bench for stack_seq_ctrl: directed instructions, a stack/SP reference model and a
// per-cycle compare process, plus hand-computed checkpoints.
module tb_stack_seq_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int SPMOD = 1 << (AW + 1);
`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0, instr_ready;
    logic          alu_op = 1'b0;
    logic [1:0]    pc_src = 2'b00;
    logic          mem_read = 1'b0, mem_write = 1'b0;
    logic [1:0]    wr_src = 2'b00;
    logic          alu_src = 1'b0;
    logic [1:0]    upd_mode = 2'b00;
    logic          alu_op_q;
    logic [AW-1:0] stk_addr;
    logic          stk_re, stk_we;
    logic [DW-1:0] stk_wdata, stk_rdata;
    logic [DW-1:0] op_top, op_nxt;
    logic          alu_go;
    logic [DW-1:0] alu_result = '0;
    logic          dmem_req, dmem_we;
    logic          dmem_ack = 1'b0;
    logic [DW-1:0] dmem_rdata = '0;
    logic [DW-1:0] pc_plus1 = '0;
    logic          pc_we;
    logic [1:0]    pc_sel;
    logic [AW:0]   sp;
    logic          done, err;

    stack_seq_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .alu_op(alu_op), .pc_src(pc_src), .mem_read(mem_read), .mem_write(mem_write),
        .wr_src(wr_src), .alu_src(alu_src), .upd_mode(upd_mode), .alu_op_q(alu_op_q),
        .stk_addr(stk_addr), .stk_re(stk_re), .stk_we(stk_we), .stk_wdata(stk_wdata),
        .stk_rdata(stk_rdata), .op_top(op_top), .op_nxt(op_nxt), .alu_go(alu_go),
        .alu_result(alu_result), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .pc_plus1(pc_plus1), .pc_we(pc_we), .pc_sel(pc_sel),
        .sp(sp), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Single-port synchronous stack RAM
    logic [DW-1:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (stk_we) ram[stk_addr] <= stk_wdata;
        if (stk_re) stk_rdata <= ram[stk_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expectations for the instruction in flight (written by the driver only)
    int            x_sp0, x_new_sp, x_lat, x_waddr;
    bit            x_abort, x_mem, x_mw, x_we, x_aluop;
    logic [DW-1:0] x_wdata, x_top, x_nxt;
    logic [1:0]    x_pcsel;
    int            n_issued = 0;

    // Reference state (written by the compare process only)
    int            m_sp = 0;
    bit            m_err = 1'b0;
    logic [DW-1:0] m_stack [0:DEPTH-1];
    int            n_retired = 0;
    int            cur_k = 0;
    int            last_lat = 0;

    // dmem responder: ack after d_wait cycles of request
    int            d_wait = 0, d_cnt = 0;
    logic [DW-1:0] d_rdata = '0;
    always @(negedge clk) begin
        if (dmem_req && d_cnt == d_wait) begin
            dmem_ack   = 1'b1;
            dmem_rdata = d_rdata;
        end else begin
            dmem_ack   = 1'b0;
            dmem_rdata = 32'hDEAD_BEEF;
            d_cnt      = dmem_req ? d_cnt + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m_sp      = 0;
            m_err     = 1'b0;
            cur_k     = 0;
            n_retired = n_issued;
        end else if (n_issued != n_retired) begin
            cur_k++;
            check("done", done, cur_k == x_lat);
            check("pc_we", pc_we, cur_k == x_lat && !x_abort);
            if (pc_we) check("pc_sel", pc_sel, x_pcsel);
            check("stk_we", stk_we, cur_k == x_lat && x_we);
            if (stk_we) begin
                check("wr_addr", stk_addr, x_waddr);
                check("wr_data", stk_wdata, x_wdata);
            end
            check("stk_re", stk_re, !x_abort && ((cur_k == 1 && x_sp0 >= 1) || (cur_k == 2 && x_sp0 >= 2)));
            if (stk_re) check("rd_addr", stk_addr, (x_sp0 - cur_k + SPMOD) % DEPTH);
            check("alu_go", alu_go, cur_k == 3 && !x_abort);
            check("dmem_req", dmem_req, !x_abort && x_mem && cur_k >= 4 && cur_k < x_lat);
            check("dmem_we", dmem_we, !x_abort && x_mw && cur_k >= 4 && cur_k < x_lat);
            check("instr_ready_busy", instr_ready, 1'b0);
            check("sp_busy", sp, x_sp0);
            if (cur_k == 3 && !x_abort) begin
                check("op_top", op_top, x_top);
                check("alu_op_q", alu_op_q, x_aluop);
            end
            if (cur_k == 4 && !x_abort) check("op_nxt", op_nxt, x_nxt);
            if (cur_k >= x_lat) begin
                last_lat = cur_k;
                if (x_abort) m_err = 1'b1;
                else begin
                    if (x_we) m_stack[x_waddr] = x_wdata;
                    m_sp = x_new_sp;
                end
                cur_k = 0;
                n_retired++;
            end
        end else begin
            check("instr_ready_idle", instr_ready, 1'b1);
            check("done_idle", done, 1'b0);
            check("stk_we_idle", stk_we, 1'b0);
            check("dmem_req_idle", dmem_req, 1'b0);
            check("sp_idle", sp, m_sp);
            check("err_idle", err, m_err);
        end
    end

    task automatic issue(input logic a_op, input logic [1:0] a_pc, input logic a_mr, input logic a_mw,
                         input logic [1:0] a_wr, input logic a_src, input logic [1:0] a_upd,
                         input logic [DW-1:0] a_alu, input int a_dwait, input logic [DW-1:0] a_drd,
                         input logic [DW-1:0] a_pcp1);
        int need, delta;
        bit ovf;
        if (a_upd == 2'b10 || (a_upd == 2'b11 && a_wr == 2'b01 && !a_src)) need = 2;
        else if (a_upd == 2'b11 || (a_upd == 2'b00 && a_wr != 2'b00)) need = 1;
        else need = 0;
        ovf = (a_upd == 2'b01) && (m_sp == DEPTH);
        case (a_upd)
            2'b01:   delta = 1;
            2'b10:   delta = -2;
            2'b11:   delta = -1;
            default: delta = 0;
        endcase
        x_sp0    = m_sp;
        x_abort  = BOUNDS && (m_sp < need || ovf);
        x_new_sp = (m_sp + delta + SPMOD) % SPMOD;
        x_mem    = a_mr || a_mw;
        x_mw     = a_mw;
        x_lat    = x_abort ? 1 : (x_mem ? 5 + a_dwait : 4);
        x_we     = !x_abort && a_wr != 2'b00;
        x_waddr  = (x_new_sp - 1 + SPMOD) % DEPTH;
        x_wdata  = (a_wr == 2'b01) ? a_alu : (a_wr == 2'b10) ? a_drd : a_pcp1;
        x_top    = (m_sp >= 1) ? m_stack[(m_sp - 1) % DEPTH] : '0;
        x_nxt    = (m_sp >= 2) ? m_stack[(m_sp - 2) % DEPTH] : '0;
        x_pcsel  = a_pc;
        x_aluop  = a_op;
        @(negedge clk);
        instr_valid = 1'b1;
        alu_op = a_op; pc_src = a_pc; mem_read = a_mr; mem_write = a_mw;
        wr_src = a_wr; alu_src = a_src; upd_mode = a_upd;
        alu_result = a_alu; d_wait = a_dwait; d_rdata = a_drd; pc_plus1 = a_pcp1;
        @(posedge clk);
        #1;
        n_issued++;
        // Garbage on the inputs while busy must be ignored
        alu_op = ~a_op; pc_src = ~a_pc; mem_read = ~a_mr; mem_write = ~a_mw;
        wr_src = ~a_wr; alu_src = ~a_src; upd_mode = ~a_upd;
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    task automatic wait_retire();
        for (int i = 0; i < 100 && n_retired != n_issued; i++) @(negedge clk);
        #1;
        instr_valid = 1'b0;
        if (n_retired != n_issued) begin
            check("retire_timeout", n_retired, n_issued);
            finish_run();
        end
    endtask

    task automatic run(input logic a_op, input logic [1:0] a_pc, input logic a_mr, input logic a_mw,
                       input logic [1:0] a_wr, input logic a_src, input logic [1:0] a_upd,
                       input logic [DW-1:0] a_alu, input int a_dwait, input logic [DW-1:0] a_drd,
                       input logic [DW-1:0] a_pcp1);
        issue(a_op, a_pc, a_mr, a_mw, a_wr, a_src, a_upd, a_alu, a_dwait, a_drd, a_pcp1);
        instr_valid = 1'b0;
        wait_retire();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_sp", sp, 0);
        check("rst_op_top", op_top, 0);
        check("rst_op_nxt", op_nxt, 0);
        check("rst_err", err, 0);
        check("rst_pc_sel", pc_sel, 0);
        check("rst_alu_op_q", alu_op_q, 0);
        check("rst_strobes", {done, stk_we, stk_re, pc_we, alu_go, dmem_req}, 6'b0);
        check("rst_ready", instr_ready, 1);
        #1 rst_n = 1'b1;

        // 1: three pushes of immediates computed by the ALU
        run(0, 2'b00, 0, 0, 2'b01, 1, 2'b01, 32'd5, 0, '0, 32'h10);
        check("push1_lat", last_lat, 4);
        run(0, 2'b00, 0, 0, 2'b01, 1, 2'b01, 32'd6, 0, '0, 32'h11);
        run(0, 2'b00, 0, 0, 2'b01, 1, 2'b01, 32'd7, 0, '0, 32'h12);
        check("push3_lat", last_lat, 4);
        check("push_sp", sp, 3);
        check("ram0", ram[0], 5);
        check("ram1", ram[1], 6);
        check("ram2", ram[2], 7);

        // 2: add at sp=3
        run(0, 2'b00, 0, 0, 2'b01, 0, 2'b11, 32'd13, 0, '0, 32'h13);
        check("add_op_top", op_top, 7);
        check("add_op_nxt", op_nxt, 6);
        check("add_sp", sp, 2);
        check("add_ram1", ram[1], 13);

        // 3: load replacing top, ack after 3 wait cycles
        run(1, 2'b00, 1, 0, 2'b10, 0, 2'b00, 32'h77, 3, 32'hA5, 32'h14);
        check("load_lat", last_lat, 8);
        check("load_sp", sp, 2);
        check("load_top", ram[1], 32'hA5);

        // PC_temp push, then a store popping two with immediate ack
        run(0, 2'b01, 0, 0, 2'b11, 0, 2'b01, 32'h0, 0, '0, 32'h1234);
        check("pcpush_ram2", ram[2], 32'h1234);
        run(1, 2'b00, 0, 1, 2'b00, 0, 2'b10, 32'h0, 0, '0, 32'h15);
        check("store_lat", last_lat, 5);
        check("store_sp", sp, 1);

        // 4: pop_pc at sp=1
        run(0, 2'b10, 0, 0, 2'b00, 0, 2'b11, 32'h0, 0, '0, 32'h16);
        check("poppc_sel", pc_sel, 2'b10);
        check("poppc_sp", sp, 0);

        // 6: reset while waiting in MEM
        issue(0, 2'b00, 1, 0, 2'b10, 0, 2'b01, 32'h0, 20, 32'h99, 32'h17);
        instr_valid = 1'b0;
        for (int i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
        check("mem_entered", dmem_req, 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_dmem_req", dmem_req, 0);
        check("rstmid_sp", sp, 0);
        check("rstmid_ready", instr_ready, 1);
        check("rstmid_we", stk_we, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run(0, 2'b00, 0, 0, 2'b01, 1, 2'b01, 32'd42, 0, '0, 32'h18);
        check("after_rst_sp", sp, 1);
        check("after_rst_ram0", ram[0], 42);
        run(0, 2'b00, 0, 0, 2'b00, 0, 2'b11, 32'h0, 0, '0, 32'h19);

        // 5: pop at sp=0
        run(0, 2'b10, 0, 0, 2'b00, 0, 2'b11, 32'h0, 0, '0, 32'h1A);
`ifdef STACK_BOUNDS_CHECK_EN
        check("uflow_err", err, 1);
        check("uflow_sp", sp, 0);
        check("uflow_lat", last_lat, 1);
`else
        check("wrap_sp", sp, SPMOD - 1);
        check("wrap_err", err, 0);
        check("wrap_lat", last_lat, 4);
`endif
        repeat (2) @(negedge clk);
        finish_run();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
